// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer control core: random wait, stimulus LED, BCD millisecond measurement.
// Optional best-time register enabled by defining REACTION_BEST_TIME_EN.
module reaction_timer_ctrl #(
    parameter int unsigned CLKS_PER_MS  = 100000,
    parameter int unsigned MIN_DELAY_MS = 2000,
    parameter int unsigned RAND_BITS    = 12
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_tick_i,
    input  logic        stop_tick_i,
    input  logic        clear_tick_i,
    output logic        led_o,
    output logic [15:0] bcd_o,
    output logic [2:0]  status_o
`ifdef REACTION_BEST_TIME_EN
    ,
    output logic [15:0] best_bcd_o
`endif
);

    localparam int unsigned PRESC_W = $clog2(CLKS_PER_MS);
    localparam int unsigned MAX_D   = MIN_DELAY_MS + (32'd1 << RAND_BITS) - 32'd1;
    localparam int unsigned WAIT_W  = $clog2(MAX_D + 1);

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [15:0] BCD_TIMEOUT = 16'h1000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_CHEAT   = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_led;
    logic [15:0]         r_bcd;
    logic [15:0]         r_lfsr;
    logic [PRESC_W-1:0]  r_presc;
    logic [WAIT_W-1:0]   r_wait;

    logic                w_lfsr_fb;
    logic                w_ms_tick;
    logic [15:0]         w_bcd_inc;
    logic                w_carry;

    // Taps 16,14,13,11 (1-based); XOR form cannot lock up from a non-zero seed
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_ms_tick = (r_presc == PRESC_W'(CLKS_PER_MS - 1));

    // Cascaded decimal increment of the four BCD digits
    always_comb begin
        w_bcd_inc = r_bcd;
        w_carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_bcd[i*4 +: 4] == 4'd9) begin
                    w_bcd_inc[i*4 +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_led   <= 1'b0;
            r_bcd   <= 16'h0000;
            r_lfsr  <= LFSR_SEED;
            r_presc <= '0;
            r_wait  <= '0;
        end else begin
            r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
            r_presc <= w_ms_tick ? '0 : r_presc + PRESC_W'(1);

            if (clear_tick_i) begin
                r_state <= S_IDLE;
                r_led   <= 1'b0;
                r_bcd   <= 16'h0000;
                r_presc <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_tick_i) begin
                            r_state <= S_WAIT;
                            r_wait  <= WAIT_W'(MIN_DELAY_MS) + WAIT_W'(r_lfsr[RAND_BITS-1:0]);
                            r_bcd   <= 16'h0000;
                            r_presc <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (stop_tick_i) begin
                            r_state <= S_CHEAT;
                        end else if (w_ms_tick) begin
                            r_wait <= r_wait - WAIT_W'(1);
                            if (r_wait <= WAIT_W'(1)) begin
                                r_state <= S_RUN;
                                r_led   <= 1'b1;
                                r_presc <= '0;
                            end
                        end
                    end
                    S_RUN: begin
                        // Stop wins over a coincident tick, freezing the pre-tick count
                        if (stop_tick_i) begin
                            r_state <= S_DONE;
                            r_led   <= 1'b0;
                        end else if (w_ms_tick) begin
                            r_bcd <= w_bcd_inc;
                            if (w_bcd_inc == BCD_TIMEOUT) begin
                                r_state <= S_TIMEOUT;
                                r_led   <= 1'b0;
                            end
                        end
                    end
                    S_DONE, S_CHEAT, S_TIMEOUT: begin
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_led   <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef REACTION_BEST_TIME_EN
    logic [15:0] r_best;

    // BCD digits compare correctly as plain unsigned values
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_best <= 16'h9999;
        end else if (!clear_tick_i && stop_tick_i && r_state == S_RUN && r_bcd < r_best) begin
            r_best <= r_bcd;
        end
    end

    assign best_bcd_o = r_best;
`endif

    assign led_o    = r_led;
    assign bcd_o    = r_bcd;
    assign status_o = 3'(r_state);

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_reaction_timer_ctrl;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_CHEAT   = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_tick_i = 1'b0;
    logic        stop_tick_i = 1'b0;
    logic        clear_tick_i = 1'b0;
    logic        led_o;
    logic [15:0] bcd_o;
    logic [2:0]  status_o;
`ifdef REACTION_BEST_TIME_EN
    logic [15:0] best_bcd_o;
    logic [15:0] exp_best = 16'h9999;
`endif

    reaction_timer_ctrl #(
        .CLKS_PER_MS (4),
        .MIN_DELAY_MS(3),
        .RAND_BITS   (2)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_tick_i(start_tick_i),
        .stop_tick_i (stop_tick_i),
        .clear_tick_i(clear_tick_i),
        .led_o       (led_o),
        .bcd_o       (bcd_o),
        .status_o    (status_o)
`ifdef REACTION_BEST_TIME_EN
        ,
        .best_bcd_o  (best_bcd_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  st;
        logic        led;
        logic [15:0] bcd;
`ifdef REACTION_BEST_TIME_EN
        logic [15:0] best;
`endif
    } exp_t;

    exp_t        q_exp[$];
    string       q_name[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [15:0] m_lfsr;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference LFSR used to predict the random delay
    always @(posedge clk_i) begin
        if (reset_i) m_lfsr <= 16'hACE1;
        else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    always @(negedge clk_i) begin
        exp_t  e;
        string nm;
        while (q_exp.size() > 0 && q_exp[0].cyc <= 32'(cyc)) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            n_checks++;
            if (e.cyc != 32'(cyc)) begin
                n_fail++;
                $display("FAIL %s: compared at cycle %0d, required cycle %0d", nm, cyc, e.cyc);
            end else if (status_o !== e.st || led_o !== e.led || bcd_o !== e.bcd
`ifdef REACTION_BEST_TIME_EN
                         || best_bcd_o !== e.best
`endif
                        ) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got status=%0d led=%0b bcd=%h, expected status=%0d led=%0b bcd=%h",
                         nm, cyc, status_o, led_o, bcd_o, e.st, e.led, e.bcd);
`ifdef REACTION_BEST_TIME_EN
                $display("    %s best: got %h expected %h", nm, best_bcd_o, e.best);
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drive(input logic s, input logic p, input logic c);
        start_tick_i = s;
        stop_tick_i  = p;
        clear_tick_i = c;
        step(1);
        start_tick_i = 1'b0;
        stop_tick_i  = 1'b0;
        clear_tick_i = 1'b0;
    endtask

    task automatic expect_now(input string nm, input logic [2:0] st, input logic led, input logic [15:0] bcd);
        exp_t e;
        e.cyc = 32'(cyc);
        e.st  = st;
        e.led = led;
        e.bcd = bcd;
`ifdef REACTION_BEST_TIME_EN
        e.best = exp_best;
`endif
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic note_done(input logic [15:0] bcd);
`ifdef REACTION_BEST_TIME_EN
        if (bcd < exp_best) exp_best = bcd;
`else
        if (bcd == 16'hFFFF) $display("note: unexpected result %h", bcd);
`endif
    endtask

    // Start from IDLE and follow WAIT into RUN; returns at the RUN entry edge
    task automatic start_run();
        int d;
        d = 3 + int'(m_lfsr[1:0]);
        drive(1'b1, 1'b0, 1'b0);
        expect_now("wait_entry", ST_WAIT, 1'b0, 16'h0000);
        step(4 * d - 1);
        expect_now("wait_last", ST_WAIT, 1'b0, 16'h0000);
        step(1);
        expect_now("run_entry", ST_RUN, 1'b1, 16'h0000);
    endtask

    task automatic stop_after(input int k, input logic [15:0] bcd);
        step(4 * k);
        expect_now("run_count", ST_RUN, 1'b1, bcd);
        drive(1'b0, 1'b1, 1'b0);
        note_done(bcd);
        expect_now("done", ST_DONE, 1'b0, bcd);
    endtask

    initial begin
        #8_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset and ignored ticks in IDLE
        step(2);
        expect_now("reset", ST_IDLE, 1'b0, 16'h0000);
        reset_i = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        expect_now("idle_stop", ST_IDLE, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 1'b1);
        expect_now("idle_clear", ST_IDLE, 1'b0, 16'h0000);

        // 2./3. measured run of 37 ms, ignored ticks in DONE, clear
        start_run();
        step(4);
        expect_now("first_tick", ST_RUN, 1'b1, 16'h0001);
        stop_after(36, 16'h0037);
        drive(1'b1, 1'b0, 1'b0);
        expect_now("done_start", ST_DONE, 1'b0, 16'h0037);
        drive(1'b0, 1'b1, 1'b0);
        expect_now("done_stop", ST_DONE, 1'b0, 16'h0037);
        drive(1'b0, 1'b0, 1'b1);
        expect_now("done_clear", ST_IDLE, 1'b0, 16'h0000);

        // 4. early press
        drive(1'b1, 1'b0, 1'b0);
        expect_now("cheat_wait", ST_WAIT, 1'b0, 16'h0000);
        step(1);
        drive(1'b0, 1'b1, 1'b0);
        expect_now("cheat", ST_CHEAT, 1'b0, 16'h0000);
        for (int i = 0; i < 10000; i++) begin
            step(1);
            expect_now("cheat_hold", ST_CHEAT, 1'b0, 16'h0000);
        end
        drive(1'b0, 1'b0, 1'b1);
        expect_now("cheat_clear", ST_IDLE, 1'b0, 16'h0000);

        // 5. timeout, then stop coincident with the 1000th tick
        start_run();
        step(3999);
        expect_now("pre_timeout", ST_RUN, 1'b1, 16'h0999);
        step(1);
        expect_now("timeout", ST_TIMEOUT, 1'b0, 16'h1000);
        drive(1'b0, 1'b1, 1'b0);
        expect_now("timeout_stop", ST_TIMEOUT, 1'b0, 16'h1000);
        drive(1'b0, 1'b0, 1'b1);
        expect_now("timeout_clear", ST_IDLE, 1'b0, 16'h0000);
        start_run();
        step(3999);
        drive(1'b0, 1'b1, 1'b0);
        note_done(16'h0999);
        expect_now("stop_at_1000", ST_DONE, 1'b0, 16'h0999);
        drive(1'b0, 1'b0, 1'b1);

        // stop coincident with an ordinary tick drops that tick
        start_run();
        step(19);
        drive(1'b0, 1'b1, 1'b0);
        note_done(16'h0004);
        expect_now("stop_on_tick", ST_DONE, 1'b0, 16'h0004);
        drive(1'b0, 1'b0, 1'b1);

        // 6. clear and stop together in RUN
        start_run();
        step(20);
        expect_now("run_5ms", ST_RUN, 1'b1, 16'h0005);
        drive(1'b0, 1'b1, 1'b1);
        expect_now("clear_over_stop", ST_IDLE, 1'b0, 16'h0000);

        // reset mid-WAIT; restart right after reset sees seed ACE1 so D = 3 + 1 = 4
        drive(1'b1, 1'b0, 1'b0);
        step(3);
        reset_i = 1'b1;
        step(1);
`ifdef REACTION_BEST_TIME_EN
        exp_best = 16'h9999;
`endif
        expect_now("reset_mid_wait", ST_IDLE, 1'b0, 16'h0000);
        reset_i = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        expect_now("reseed_wait", ST_WAIT, 1'b0, 16'h0000);
        step(15);
        expect_now("reseed_wait_last", ST_WAIT, 1'b0, 16'h0000);
        step(1);
        expect_now("reseed_run", ST_RUN, 1'b1, 16'h0000);
        drive(1'b0, 1'b0, 1'b1);
        expect_now("reseed_clear", ST_IDLE, 1'b0, 16'h0000);

        // best-time sequence: 250, 180, 300 ms
        start_run();
        stop_after(250, 16'h0250);
        drive(1'b0, 1'b0, 1'b1);
        start_run();
        stop_after(180, 16'h0180);
        drive(1'b0, 1'b0, 1'b1);
        start_run();
        stop_after(300, 16'h0300);
        drive(1'b0, 1'b0, 1'b1);
        expect_now("best_final", ST_IDLE, 1'b0, 16'h0000);
`ifdef REACTION_BEST_TIME_EN
        if (exp_best != 16'h0180) $display("note: best model holds %h", exp_best);
`endif

        step(2);
        while (q_exp.size() > 0) begin
            exp_t  e;
            string nm;
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never compared, required at cycle %0d", nm, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
